ll_window_detector: RTL and testbench



---
 rtl/ll_pkg.sv | 18 +
 rtl/ll_window_buf.sv | 40 ++++
 rtl/ll_window_detector.sv | 136 +++++++++++++
 tb/tb_ll_window_detector.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared definitions for the line-length window detector.
package ll_pkg;

    // Detector FSM: filling the first window, then steady sliding operation.
    typedef enum logic {
        FILL,
        RUN
    } ll_state_e;

    localparam int LL_IN_WIDTH    = 33;
    localparam int LL_WIN_LEN_DEF = 256;

    // Unsigned window-sum width: clamped sample magnitude plus log2 growth.
    function automatic int ll_sum_width(input int in_width, input int win_len);
        return in_width - 1 + $clog2(win_len);
    endfunction

endpackage

// File: rtl/ll_window_buf.sv
// Circular sample buffer: reads the oldest entry and overwrites it with the
// newest sample at the same address, then advances the write pointer.
module ll_window_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;

    // Oldest entry lives at the slot about to be overwritten.
    assign rd_data  = mem[wr_ptr_q];
    assign wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;

    // Write pointer; wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is deliberately not reset; stale data is never consumed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ll_window_detector.sv
// Sliding-window line-length sum with debounced over-threshold detect.
// Optional macro LL_PEAK_HOLD_EN adds a peak_sum output tracking the
// largest full-window sum seen since reset.
module ll_window_detector
    import ll_pkg::*;
#(
    parameter int  IN_WIDTH  = LL_IN_WIDTH,
    parameter int  WIN_LEN   = LL_WIN_LEN_DEF,
    parameter int  HOLD_CNT  = 4,
    localparam int SUM_WIDTH = ll_sum_width(IN_WIDTH, WIN_LEN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [IN_WIDTH-1:0] din,
    input  logic                       din_valid,
    input  logic [SUM_WIDTH-1:0]       threshold,
    output logic [SUM_WIDTH-1:0]       dout,
    output logic                       dout_valid,
    output logic                       detect
`ifdef LL_PEAK_HOLD_EN
    ,
    output logic [SUM_WIDTH-1:0]       peak_sum
`endif
);

    localparam int SMP_W  = IN_WIDTH - 1;
    localparam int FILL_W = $clog2(WIN_LEN);
    localparam int HIT_W  = $clog2(HOLD_CNT + 1);

    ll_state_e            state_q, state_d;
    logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [HIT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic                 detect_q, detect_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [SMP_W-1:0]     sample;
    logic [SMP_W-1:0]     oldest;
    logic [SMP_W-1:0]     old_term;
    logic                 window_done;
`ifdef LL_PEAK_HOLD_EN
    logic [SUM_WIDTH-1:0] peak_q, peak_d;
`endif

    // Negative increments carry no line length; clamp them to zero.
    assign sample = din[IN_WIDTH-1] ? '0 : din[SMP_W-1:0];

    ll_window_buf #(
        .DATA_W (SMP_W),
        .DEPTH  (WIN_LEN)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (din_valid),
        .wr_data (sample),
        .rd_data (oldest)
    );

    // Next-state: FSM, running sum and detector; detection uses the new sum.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        sum_d        = sum_q;
        hit_cnt_d    = hit_cnt_q;
        detect_d     = detect_q;
        dout_valid_d = 1'b0;
        old_term     = (state_q == RUN) ? oldest : '0;
        window_done  = 1'b0;
`ifdef LL_PEAK_HOLD_EN
        peak_d       = peak_q;
`endif
        if (din_valid) begin
            sum_d = sum_q + SUM_WIDTH'(sample) - SUM_WIDTH'(old_term);
            if (state_q == FILL) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
                if (fill_cnt_q == FILL_W'(WIN_LEN - 1)) begin
                    state_d     = RUN;
                    window_done = 1'b1;
                end
            end else begin
                window_done = 1'b1;
            end
        end
        if (window_done) begin
            dout_valid_d = 1'b1;
            if (sum_d > threshold) begin
                if (hit_cnt_q < HIT_W'(HOLD_CNT)) begin
                    hit_cnt_d = hit_cnt_q + 1'b1;
                end
                if (hit_cnt_q >= HIT_W'(HOLD_CNT - 1)) begin
                    detect_d = 1'b1;
                end
            end else begin
                hit_cnt_d = '0;
                detect_d  = 1'b0;
            end
`ifdef LL_PEAK_HOLD_EN
            if (sum_d > peak_q) begin
                peak_d = sum_d;
            end
`endif
        end
    end

    // State registers with synchronous reset back to an empty FILL phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            fill_cnt_q   <= '0;
            sum_q        <= '0;
            hit_cnt_q    <= '0;
            detect_q     <= 1'b0;
            dout_valid_q <= 1'b0;
`ifdef LL_PEAK_HOLD_EN
            peak_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            sum_q        <= sum_d;
            hit_cnt_q    <= hit_cnt_d;
            detect_q     <= detect_d;
            dout_valid_q <= dout_valid_d;
`ifdef LL_PEAK_HOLD_EN
            peak_q       <= peak_d;
`endif
        end
    end

    assign dout       = sum_q;
    assign dout_valid = dout_valid_q;
    assign detect     = detect_q;
`ifdef LL_PEAK_HOLD_EN
    assign peak_sum   = peak_q;
`endif

endmodule

// File: tb/tb_ll_window_detector.sv
// Directed bench for ll_window_detector with WIN_LEN=4, HOLD_CNT=2.
// Peak-hold checks are included when LL_PEAK_HOLD_EN is defined.
module tb_ll_window_detector;

    localparam int IN_W  = 33;
    localparam int SUM_W = 34;

    logic                   clk = 1'b0;
    logic                   rst;
    logic signed [IN_W-1:0] din;
    logic                   din_valid;
    logic [SUM_W-1:0]       threshold;
    logic [SUM_W-1:0]       dout;
    logic                   dout_valid;
    logic                   detect;
`ifdef LL_PEAK_HOLD_EN
    logic [SUM_W-1:0]       peak_sum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ll_window_detector #(
        .IN_WIDTH (IN_W),
        .WIN_LEN  (4),
        .HOLD_CNT (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .threshold  (threshold),
        .dout       (dout),
        .dout_valid (dout_valid),
        .detect     (detect)
`ifdef LL_PEAK_HOLD_EN
        ,
        .peak_sum   (peak_sum)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample; outputs are sampled 1 time unit after the edge.
    task automatic push(input logic signed [IN_W-1:0] d);
        din       = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = '0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Checks a full output triple after a step.
    task automatic expect_out(input string tag, input logic v, input logic [SUM_W-1:0] s, input logic det);
        check({tag, "_valid"}, 64'(dout_valid), 64'(v));
        if (v) check({tag, "_dout"}, 64'(dout), 64'(s));
        check({tag, "_detect"}, 64'(detect), 64'(det));
    endtask

    logic [SUM_W-1:0] big4;
    logic [SUM_W-1:0] big3;

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        threshold = 34'd100;
        big4      = 34'd17179869180;
        big3      = 34'd12884901885;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_dout", 64'(dout), 64'd0);
        check("reset_valid", 64'(dout_valid), 64'd0);
        check("reset_detect", 64'(detect), 64'd0);
`ifdef LL_PEAK_HOLD_EN
        check("reset_peak", 64'(peak_sum), 64'd0);
`endif
        rst = 1'b0;

        // First window: equality with threshold is not a hit.
        push(33'sd10); expect_out("fill1", 1'b0, '0, 1'b0);
        push(33'sd20); expect_out("fill2", 1'b0, '0, 1'b0);
        push(33'sd30); expect_out("fill3", 1'b0, '0, 1'b0);
        push(33'sd40); expect_out("win100", 1'b1, 34'd100, 1'b0);
        // Debounce: two consecutive hits assert detect; hit count saturates.
        push(33'sd50); expect_out("win140", 1'b1, 34'd140, 1'b0);
        push(33'sd60); expect_out("win180", 1'b1, 34'd180, 1'b1);
        push(33'sd0);  expect_out("win150", 1'b1, 34'd150, 1'b1);
        push(33'sd0);  expect_out("win110", 1'b1, 34'd110, 1'b1);
        push(33'sd0);  expect_out("win60", 1'b1, 34'd60, 1'b0);
        idle();        expect_out("idle_after", 1'b0, '0, 1'b0);
        check("idle_hold_dout", 64'(dout), 64'd60);

        // Negative sample clamps to zero.
        pulse_reset();
        expect_out("rst2", 1'b0, '0, 1'b0);
        check("rst2_dout", 64'(dout), 64'd0);
        push(33'sd10);
        push(-33'sd5);
        check("neg_sum", 64'(dout), 64'd10);
        push(33'sd10);
        push(33'sd10); expect_out("neg_win", 1'b1, 34'd30, 1'b0);

        // Reset mid-fill: stale buffer contents are never subtracted.
        pulse_reset();
        push(33'sd7);
        push(33'sd7);
        pulse_reset();
        check("midrst_dout", 64'(dout), 64'd0);
        push(33'sd1); expect_out("mr1", 1'b0, '0, 1'b0);
        push(33'sd1); expect_out("mr2", 1'b0, '0, 1'b0);
        push(33'sd1); expect_out("mr3", 1'b0, '0, 1'b0);
        check("mr3_sum", 64'(dout), 64'd3);
        push(33'sd1); expect_out("mr4", 1'b1, 34'd4, 1'b0);
        push(33'sd1); expect_out("mr5", 1'b1, 34'd4, 1'b0);

        // Gaps in din_valid: sum holds, dout_valid only after accepted samples.
        pulse_reset();
        push(33'sd25);
        idle(); expect_out("gap1", 1'b0, '0, 1'b0);
        check("gap1_hold", 64'(dout), 64'd25);
        idle(); expect_out("gap2", 1'b0, '0, 1'b0);
        push(33'sd25);
        idle();
        push(33'sd25); expect_out("gap3", 1'b0, '0, 1'b0);
        check("gap3_sum", 64'(dout), 64'd75);
        push(33'sd25); expect_out("gap_win", 1'b1, 34'd100, 1'b0);
        idle(); expect_out("gap_idle", 1'b0, '0, 1'b0);
        check("gap_idle_hold", 64'(dout), 64'd100);

        // Threshold changes apply only to subsequent accepted samples.
        threshold = 34'd99;
        push(33'sd25); expect_out("thr99a", 1'b1, 34'd100, 1'b0);
        push(33'sd25); expect_out("thr99b", 1'b1, 34'd100, 1'b1);
        threshold = 34'd200;
        idle(); expect_out("thr_noretro", 1'b0, '0, 1'b1);
        push(33'sd25); expect_out("thr200", 1'b1, 34'd100, 1'b0);

        // Maximum positive samples: no wrap in the 34-bit sum.
        threshold = 34'd100;
        pulse_reset();
        push(33'sh0FFFFFFFF);
        push(33'sh0FFFFFFFF);
        push(33'sh0FFFFFFFF);
        push(33'sh0FFFFFFFF); expect_out("max_win", 1'b1, big4, 1'b0);
`ifdef LL_PEAK_HOLD_EN
        check("peak_max", 64'(peak_sum), 64'(big4));
`endif
        push(33'sd0); expect_out("max_drop", 1'b1, big3, 1'b1);
`ifdef LL_PEAK_HOLD_EN
        check("peak_hold", 64'(peak_sum), 64'(big4));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
